// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared SDRAM command encodings and arbiter state encoding.
// Command words are {cs_n, ras_n, cas_n, we_n}.
package sdram_cmd_arbiter_pkg;

  localparam logic [3:0] SDRAM_CMD_MRS  = 4'b0000;
  localparam logic [3:0] SDRAM_CMD_AREF = 4'b0001;
  localparam logic [3:0] SDRAM_CMD_PRE  = 4'b0010;
  localparam logic [3:0] SDRAM_CMD_ACT  = 4'b0011;
  localparam logic [3:0] SDRAM_CMD_WR   = 4'b0100;
  localparam logic [3:0] SDRAM_CMD_RD   = 4'b0101;
  localparam logic [3:0] SDRAM_CMD_NOP  = 4'b0111;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ARB  = 2'd1,
    ST_REF  = 2'd2,
    ST_CH   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Rotating-priority picker: first requester at or after (ptr+1) mod NUM_CH.
// A pointer of NUM_CH-1 degenerates to fixed priority, lowest index first.
module sdram_rr_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_pick,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  always_comb begin
    int c;
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    c      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(i_ptr) + 1 + i) % NUM_CH;
      if (!o_any && i_req[c]) begin
        o_any     = 1'b1;
        o_pick[c] = 1'b1;
        o_idx     = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command bus arbiter: init owns the bus until done, then refresh beats user channels.
// Define SDRAM_ARB_RR_EN for round-robin among user channels; otherwise fixed priority (ch0 highest).
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int CMD_W  = 4
) (
  input  logic                     clk_100m,
  input  logic                     sysrst_n,
  input  logic                     i_init_done,
  input  logic [CMD_W-1:0]         i_init_cmd,
  input  logic [BA_W-1:0]          i_init_ba,
  input  logic [ADDR_W-1:0]        i_init_addr,
  input  logic                     i_ref_req,
  output logic                     o_ref_en,
  input  logic [CMD_W-1:0]         i_ref_cmd,
  input  logic [BA_W-1:0]          i_ref_ba,
  input  logic [ADDR_W-1:0]        i_ref_addr,
  input  logic                     i_ref_done,
  input  logic [NUM_CH-1:0]        i_ch_req,
  output logic [NUM_CH-1:0]        o_ch_gnt,
  input  logic [NUM_CH*CMD_W-1:0]  i_ch_cmd,
  input  logic [NUM_CH*BA_W-1:0]   i_ch_ba,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH-1:0]        i_ch_done,
  output logic [CMD_W-1:0]         o_sdram_cmd,
  output logic [BA_W-1:0]          o_sdram_ba,
  output logic [ADDR_W-1:0]        o_sdram_addr,
  output logic [NUM_CH-1:0]        o_dq_oe_sel
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              ch_fin;

  sdram_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req  (i_ch_req),
    .i_ptr  (rr_ptr),
    .o_pick (pick_oh),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // Done pulses from channels other than the current owner are masked off.
  assign ch_fin = |(i_ch_done & gnt_q);

  always_ff @(posedge clk_100m or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= ST_INIT;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: if (i_init_done) state_d = ST_ARB;
      ST_ARB: begin
        if (i_ref_req) begin
          state_d = ST_REF;
        end else if (pick_any) begin
          state_d = ST_CH;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
        end
      end
      ST_REF: if (i_ref_done) state_d = ST_ARB;
      ST_CH: begin
        if (ch_fin) begin
          state_d = ST_ARB;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef SDRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk_100m or negedge sysrst_n) begin
    if (!sysrst_n) begin
      ptr_q <= IDX_W'(NUM_CH - 1);
    end else if (state_q == ST_ARB && state_d == ST_CH) begin
      ptr_q <= pick_idx;
    end
  end

  assign rr_ptr = ptr_q;
`else
  assign rr_ptr = IDX_W'(NUM_CH - 1);
`endif

  assign o_ref_en    = (state_q == ST_REF);
  assign o_ch_gnt    = gnt_q;
  assign o_dq_oe_sel = gnt_q;

  always_comb begin
    o_sdram_cmd  = CMD_W'(SDRAM_CMD_NOP);
    o_sdram_ba   = '1;
    o_sdram_addr = '1;
    case (state_q)
      ST_INIT: begin
        o_sdram_cmd  = i_init_cmd;
        o_sdram_ba   = i_init_ba;
        o_sdram_addr = i_init_addr;
      end
      ST_REF: begin
        o_sdram_cmd  = i_ref_cmd;
        o_sdram_ba   = i_ref_ba;
        o_sdram_addr = i_ref_addr;
      end
      ST_CH: begin
        o_sdram_cmd  = i_ch_cmd[int'(idx_q)*CMD_W +: CMD_W];
        o_sdram_ba   = i_ch_ba[int'(idx_q)*BA_W +: BA_W];
        o_sdram_addr = i_ch_addr[int'(idx_q)*ADDR_W +: ADDR_W];
      end
      default: ;
    endcase
  end

endmodule
